uart_tx_arbiter: RTL and testbench

//  Shares the single UARTTransmitter among NUM_REQ byte-stream requesters: board renderer, banner ROM printer, ANSI/CRLF formatter.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter:
// FSM encoding, default byte width and display ASCII codes.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_FETCH,
      ARB_STROBE,
      ARB_WAIT
   } arb_state_t;

   localparam int DEF_DATA_W = 8;

   localparam logic [7:0] ASCII_CR  = 8'd13;
   localparam logic [7:0] ASCII_LF  = 8'd10;
   localparam logic [7:0] ASCII_ESC = 8'd27;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr,
// scanning modulo NUM_REQ. Reusable by any arbiter.
module rr_picker #(
   parameter int NUM_REQ = 3,
   localparam int PTR_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win,
   output logic               any
);

   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      win   = '0;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // explicit wrap: NUM_REQ need not be a power of two
         idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin arbiter sharing one UART transmitter
// among NUM_REQ byte-stream requesters, with stall timeout.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int HOLD_TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic                      timeout_pulse
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_t           state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     g_idx;
   logic [PTR_W-1:0]     win_idx;
   logic [CNT_W-1:0]     idle_cnt;
   logic                 last_q;
   logic [NUM_REQ-1:0]   win;
   logic                 any;
   logic                 sel_valid;
   logic                 sel_last;
   logic [DATA_W-1:0]    sel_data;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req (req_valid),
      .ptr (rr_ptr),
      .win (win),
      .any (any)
   );

   always_comb begin
      win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win[k]) win_idx = PTR_W'(k);
      end
   end

   assign sel_valid = req_valid[g_idx];
   assign sel_last  = req_last[g_idx];
   assign sel_data  = req_data[g_idx*DATA_W +: DATA_W];

   // only combinational output: consume pulse in the fetch cycle
   assign req_ready = (state == ARB_FETCH && sel_valid) ? grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB_IDLE;
         rr_ptr        <= PTR_W'(NUM_REQ - 1);
         g_idx         <= '0;
         idle_cnt      <= '0;
         last_q        <= 1'b0;
         grant         <= '0;
         busy          <= 1'b0;
         tx_data       <= '0;
         tx_valid      <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         unique case (state)
            ARB_IDLE: begin
               if (any) begin
                  grant    <= win;
                  busy     <= 1'b1;
                  g_idx    <= win_idx;
                  idle_cnt <= '0;
                  state    <= ARB_FETCH;
               end
            end
            ARB_FETCH: begin
               if (sel_valid) begin
                  tx_data  <= sel_data;
                  last_q   <= sel_last;
                  idle_cnt <= '0;
                  state    <= ARB_STROBE;
               end else if (idle_cnt == CNT_LAST) begin
                  grant         <= '0;
                  busy          <= 1'b0;
                  rr_ptr        <= g_idx;
                  timeout_pulse <= 1'b1;
                  idle_cnt      <= '0;
                  state         <= ARB_IDLE;
               end else if (idle_cnt != CNT_MAX) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            ARB_STROBE: begin
               if (tx_ready && !tx_valid) begin
                  tx_valid <= 1'b1;
                  state    <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (!tx_ready) begin
                  tx_valid <= 1'b0;
                  if (last_q) begin
                     grant  <= '0;
                     busy   <= 1'b0;
                     rr_ptr <= g_idx;
                     state  <= ARB_IDLE;
                  end else begin
                     state <= ARB_FETCH;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester queues,
// a UART ready model and an expected-byte scoreboard.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam int NR = 3;
   localparam int DW = 8;
   localparam int HT = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic [DW-1:0]     tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [NR-1:0]     grant;
   logic              busy;
   logic              timeout_pulse;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .DATA_W       (DW),
      .HOLD_TIMEOUT (HT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .grant         (grant),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   int checks = 0;
   int failures = 0;
   logic [8:0]  rq0[$];
   logic [8:0]  rq1[$];
   logic [8:0]  rq2[$];
   logic [10:0] exp_q[$];
   int rdy_cnt[NR];
   int tx_count = 0;
   int ucnt = 0;
   logic ubusy = 1'b0;
   logic uart_hold = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      req_valid = {rq2.size() != 0, rq1.size() != 0, rq0.size() != 0};
      req_data  = '0;
      req_last  = '0;
      if (rq0.size() != 0) begin
         req_data[7:0] = rq0[0][7:0];
         req_last[0]   = rq0[0][8];
      end
      if (rq1.size() != 0) begin
         req_data[15:8] = rq1[0][7:0];
         req_last[1]    = rq1[0][8];
      end
      if (rq2.size() != 0) begin
         req_data[23:16] = rq2[0][7:0];
         req_last[2]     = rq2[0][8];
      end
   endtask

   task automatic push_req(input int idx, input logic [7:0] b,
                           input logic last);
      logic [2:0] oh;
      oh = 3'b001 << idx;
      case (idx)
         0: rq0.push_back({last, b});
         1: rq1.push_back({last, b});
         default: rq2.push_back({last, b});
      endcase
      exp_q.push_back({oh, b});
      refresh();
   endtask

   task automatic clear_rdy();
      for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
   endtask

   // one clock: sample at negedge, update stimulus 1 time unit after posedge
   task automatic tick();
      logic [NR-1:0] rdy;
      logic [10:0]   e;
      logic [8:0]    d;
      logic          cap;
      cap = 1'b0;
      @(negedge clk);
      rdy = req_ready;
      for (int i = 0; i < NR; i++) if (rdy[i]) rdy_cnt[i]++;
      if (tx_valid && tx_ready && !ubusy) begin
         cap = 1'b1;
         tx_count++;
         if (exp_q.size() == 0) begin
            check("sb_unexpected_byte", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_data, e[7:0]);
            check("tx_grant", grant, e[10:8]);
         end
      end
      @(posedge clk);
      #1;
      if (rdy[0] && rq0.size() != 0) d = rq0.pop_front();
      if (rdy[1] && rq1.size() != 0) d = rq1.pop_front();
      if (rdy[2] && rq2.size() != 0) d = rq2.pop_front();
      if (cap) begin
         ubusy = 1'b1;
         ucnt  = 20;
      end else if (ubusy) begin
         if (ucnt <= 1) ubusy = 1'b0;
         else ucnt--;
      end
      tx_ready = !ubusy && !uart_hold;
      refresh();
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy || ubusy || rq0.size() != 0 ||
              rq1.size() != 0 || rq2.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      check(tag, n < 2000, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rq0.delete();
      rq1.delete();
      rq2.delete();
      exp_q.delete();
      ubusy     = 1'b0;
      ucnt      = 0;
      uart_hold = 1'b0;
      tx_ready  = 1'b1;
      refresh();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int base;
      int stall_hi;
      rst_n    = 1'b0;
      tx_ready = 1'b1;
      clear_rdy();
      refresh();
      repeat (2) @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout_pulse, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_req_ready", req_ready, 0);
      do_reset();
      tick();

      // 1: "Hi\r\n" from requester 1 alone
      clear_rdy();
      push_req(1, 8'h48, 1'b0);
      push_req(1, 8'h69, 1'b0);
      push_req(1, ASCII_CR, 1'b0);
      push_req(1, ASCII_LF, 1'b1);
      tick();
      tick();
      check("lat_edge2", tx_valid, 0);
      tick();
      check("lat_edge3", tx_valid, 1);
      wait_done("t1_drain");
      check("t1_ready_pulses", rdy_cnt[1], 4);
      check("t1_other_ready", rdy_cnt[0] + rdy_cnt[2], 0);
      check("t1_grant_clear", grant, 0);
      check("t1_busy_clear", busy, 0);

      // 2: simultaneous 2-byte packets, twice
      do_reset();
      tick();
      clear_rdy();
      for (int i = 0; i < NR; i++) begin
         push_req(i, 8'(8'h10 + i * 2), 1'b0);
         push_req(i, 8'(8'h11 + i * 2), 1'b1);
      end
      wait_done("t2_round1");
      for (int i = 0; i < NR; i++) begin
         push_req(i, 8'(8'h20 + i * 2), 1'b0);
         push_req(i, 8'(8'h21 + i * 2), 1'b1);
      end
      wait_done("t2_round2");
      check("t2_ready0", rdy_cnt[0], 4);
      check("t2_ready2", rdy_cnt[2], 4);

      // 3: requester 0 stalls mid-packet, req2 pending
      clear_rdy();
      push_req(0, 8'h41, 1'b0);
      push_req(2, 8'h61, 1'b0);
      push_req(2, 8'h62, 1'b1);
      base = tx_count;
      n = 0;
      while (tx_count == base && n < 200) begin
         tick();
         n++;
      end
      n = 0;
      while (tx_valid && n < 200) begin
         tick();
         n++;
      end
      check("t3_fetch_entry", tx_valid, 0);
      n = 0;
      while (!timeout_pulse && n < 40) begin
         tick();
         n++;
      end
      check("t3_timeout_cycles", n, HT);
      check("t3_timeout_grant", grant, 0);
      push_req(0, 8'h42, 1'b1);
      tick();
      check("t3_pulse_width", timeout_pulse, 0);
      check("t3_next_grant", grant, 3'b100);
      wait_done("t3_drain");
      check("t3_ready0", rdy_cnt[0], 2);

      // 4: single byte while the transmitter is held busy
      uart_hold = 1'b1;
      tx_ready  = 1'b0;
      push_req(2, 8'h4F, 1'b1);
      stall_hi = 0;
      repeat (50) begin
         tick();
         if (tx_valid) stall_hi++;
      end
      check("t4_stall_no_valid", stall_hi, 0);
      check("t4_stall_grant", grant, 3'b100);
      uart_hold = 1'b0;
      tx_ready  = 1'b1;
      tick();
      check("t4_valid_after_ready", tx_valid, 1);
      wait_done("t4_drain");
      check("t4_grant_clear", grant, 0);

      // 5: asynchronous reset mid-packet
      push_req(0, 8'h31, 1'b0);
      push_req(0, 8'h32, 1'b0);
      push_req(0, 8'h33, 1'b1);
      n = 0;
      while (!tx_valid && n < 100) begin
         tick();
         n++;
      end
      check("t5_valid_seen", tx_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t5_arst_tx_valid", tx_valid, 0);
      check("t5_arst_grant", grant, 0);
      check("t5_arst_req_ready", req_ready, 0);
      check("t5_arst_busy", busy, 0);
      do_reset();
      push_req(0, 8'h30, 1'b1);
      push_req(1, 8'h51, 1'b1);
      wait_done("t5_drain");

      // 6: no preemption of an owner mid-packet
      push_req(1, 8'h71, 1'b0);
      push_req(1, 8'h72, 1'b0);
      push_req(1, 8'h73, 1'b1);
      n = 0;
      while (grant != 3'b010 && n < 20) begin
         tick();
         n++;
      end
      check("t6_grant1", grant, 3'b010);
      push_req(0, 8'h70, 1'b1);
      wait_done("t6_drain");
      check("t6_grant_clear", grant, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
